// File: rtl/la_iohdx_pkg.sv
// Shared types for the la_iohdx half-duplex pad transceiver.
// State encoding and counter sizing helper.
package la_iohdx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TX,
    ST_TURN,
    ST_RX
  } state_t;

  function automatic int cntw(int dw, int turn, int sync);
    return $clog2(dw + turn + sync + 1);
  endfunction

endpackage

// File: rtl/la_dsync.sv
// SYNC-stage flop synchronizer, cleared by synchronous reset.
// Output is the oldest stage.
module la_dsync #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic nreset,
  input  logic in,
  output logic out
);

  logic [SYNC-1:0] sr;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      sr <= '0;
    end else begin
      sr[0] <= in;
      for (int i = 1; i < SYNC; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign out = sr[SYNC-1];

endmodule

// File: rtl/la_iohdx.sv
// Half-duplex single-wire transceiver driving a bidirectional pad.
// Serializes a command, optionally turns the pad and reads a response.
module la_iohdx
  import la_iohdx_pkg::*;
#(
  parameter int DW   = 8,
  parameter int TURN = 2,
  parameter int SYNC = 2
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          tx_valid,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_rd,
  output logic          tx_ready,
  output logic          rx_valid,
  output logic [DW-1:0] rx_data,
  output logic          busy,
  output logic          a,
  output logic          oe,
  output logic          ie,
  input  logic          z
);

  localparam int CW = cntw(DW, TURN, SYNC);

  state_t          state, nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [DW-1:0]   txsh, rxsh, rxnext;
  logic            rd;
  logic            zs;
  logic            hs;
  logic            cnt_one;
  logic            rx_win;

  la_dsync #(.SYNC(SYNC)) u_sync (
    .clk   (clk),
    .nreset(nreset),
    .in    (z),
    .out   (zs)
  );

  assign tx_ready = nreset && (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign hs       = tx_valid && tx_ready;
  assign cnt_one  = (cnt == CW'(1));
  assign rx_win   = (state == ST_RX) && (cnt <= CW'(DW));
  assign a        = oe & txsh[DW-1];

  always_comb begin
    rxnext    = rxsh << 1;
    rxnext[0] = zs;
  end

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt - CW'(1);
    unique case (state)
      ST_IDLE: begin
        cnt_nxt = cnt;
        if (hs) begin
          nxt     = ST_TX;
          cnt_nxt = CW'(DW);
        end
      end
      ST_TX: begin
        if (cnt_one) begin
          nxt     = rd ? ST_TURN : ST_IDLE;
          cnt_nxt = CW'(TURN);
        end
      end
      ST_TURN: begin
        if (cnt_one) begin
          nxt     = ST_RX;
          cnt_nxt = CW'(SYNC + DW);
        end
      end
      ST_RX: begin
        if (cnt_one)
          nxt = ST_IDLE;
      end
    endcase
  end

  // oe/ie are registered from next state so the pad turns on a clean edge
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      txsh     <= '0;
      rxsh     <= '0;
      rd       <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      oe       <= 1'b0;
      ie       <= 1'b0;
    end else begin
      state    <= nxt;
      cnt      <= cnt_nxt;
      oe       <= (nxt == ST_TX);
      ie       <= (nxt == ST_TURN) || (nxt == ST_RX);
      rx_valid <= (state == ST_RX) && cnt_one;
      if (hs) begin
        txsh <= tx_data;
        rd   <= tx_rd;
      end else if (state == ST_TX) begin
        txsh <= txsh << 1;
      end
      if (rx_win)
        rxsh <= rxnext;
      if ((state == ST_RX) && cnt_one)
        rx_data <= rxnext;
    end
  end

endmodule

// File: tb/tb_la_iohdx.sv
// Scoreboard bench for la_iohdx with a remote-device pad model.
// Directed cases plus randomized mixed read/write traffic.
module tb_la_iohdx;

  localparam int DW   = 8;
  localparam int TURN = 2;
  localparam int SYNC = 2;
  localparam int RLAT = 2 * DW + TURN + SYNC + 1;

  typedef struct {
    logic [DW-1:0] d;
    bit            rd;
    logic [DW-1:0] r;
    int            hs;
  } cmd_t;

  typedef struct {
    logic [DW-1:0] r;
    int            c;
  } exp_t;

  logic          clk = 0;
  logic          nreset = 0;
  logic          tx_valid = 0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_rd = 0;
  logic          tx_ready, rx_valid, busy, a, oe, ie, z;
  logic [DW-1:0] rx_data;

  logic [DW-1:0] cur_resp = '0;
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            last_hs = 0;
  int            hs_cnt = 0;
  int            hs_log[$];
  cmd_t          cmd_q[$];
  exp_t          exp_q[$];

  // remote device state
  logic [DW-1:0] frame = '0;
  int            bitcnt = 0;
  int            drv_start = -1;
  logic [DW-1:0] rresp = '0;
  logic          drv = 0;
  logic          dval = 0;
  logic          keep = 0;

  la_iohdx #(.DW(DW), .TURN(TURN), .SYNC(SYNC)) dut (
    .clk     (clk),
    .nreset  (nreset),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_rd   (tx_rd),
    .tx_ready(tx_ready),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .busy    (busy),
    .a       (a),
    .oe      (oe),
    .ie      (ie),
    .z       (z)
  );

  always #5 clk = ~clk;

  // pad cell: loopback when driven by core, else remote or bus keeper
  assign z = oe ? a : (drv ? dval : keep);

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic bad(string name);
    tests++;
    fails++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  // cycle counter and remote drive update, just after the active edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (drv_start >= 0 && cyc >= drv_start && cyc < drv_start + DW) begin
      drv  = 1;
      dval = rresp[DW-1-(cyc-drv_start)];
    end else begin
      drv = 0;
    end
  end

  // monitor: handshakes, pad frames, contention, responses
  always @(negedge clk) begin
    keep = z;
    if (!nreset) begin
      bitcnt    = 0;
      frame     = '0;
      drv_start = -1;
      cmd_q.delete();
      exp_q.delete();
    end else begin
      if (tx_valid && tx_ready) begin
        cmd_t c;
        c.d = tx_data; c.rd = tx_rd; c.r = cur_resp; c.hs = cyc;
        cmd_q.push_back(c);
        if (tx_rd) begin
          exp_t e;
          e.r = cur_resp; e.c = cyc + RLAT;
          exp_q.push_back(e);
        end
        last_hs = cyc;
        hs_cnt++;
        hs_log.push_back(cyc);
      end
      if (drv)
        chk("pad_dir", {30'd0, oe, ie}, 32'd1);
      if (oe) begin
        frame = {frame[DW-2:0], a};
        bitcnt++;
        if (bitcnt == DW) begin
          bitcnt = 0;
          if (cmd_q.size() == 0) begin
            bad("frame_unexpected");
          end else begin
            cmd_t c;
            c = cmd_q.pop_front();
            chk("frame_data", {24'd0, frame}, {24'd0, c.d});
            chk("frame_end", cyc, c.hs + DW);
            if (c.rd) begin
              drv_start = cyc + TURN + 1;
              rresp     = c.r;
            end
          end
        end
      end
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          bad("rx_unexpected");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rx_data", {24'd0, rx_data}, {24'd0, e.r});
          chk("rx_cycle", cyc, e.c);
        end
      end else if (exp_q.size() > 0 && cyc >= exp_q[0].c) begin
        void'(exp_q.pop_front());
        bad("rx_missing");
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // call just after an active edge; returns just after the handshake edge
  task automatic send(logic [DW-1:0] d, bit rd, logic [DW-1:0] r);
    int n = 0;
    tx_data  = d;
    tx_rd    = rd;
    cur_resp = r;
    tx_valid = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_ready && n < 100);
    if (!tx_ready)
      bad("handshake_timeout");
    @(posedge clk);
    #1;
    tx_valid = 0;
  endtask

  task automatic wait_cycle(int c);
    while (cyc < c) @(negedge clk);
    if (cyc != c) @(negedge clk);
  endtask

  initial begin
    int h, ok, h0;
    // reset state
    step(3);
    @(negedge clk);
    chk("reset_outs",
        {16'd0, tx_ready, oe, ie, a, rx_valid, busy, rx_data},
        32'd0);
    step(1);
    nreset = 1;
    @(negedge clk);
    chk("ready_after_reset", {30'd0, tx_ready, busy}, 32'd2);
    step(1);

    // write-only 0xA5
    send(8'hA5, 0, 8'h00);
    h = last_hs;
    wait_cycle(h + DW + 1);
    chk("wr_end_oe_ready", {30'd0, oe, tx_ready}, 32'd1);
    step(2);

    // read 0x3C -> 0xC3
    send(8'h3C, 1, 8'hC3);
    h  = last_hs;
    ok = 1;
    for (int k = DW + 1; k <= RLAT - 1; k++) begin
      wait_cycle(h + k);
      if (oe !== 1'b0 || ie !== 1'b1) ok = 0;
    end
    chk("rd_turn_dir", ok, 1);
    wait_cycle(h + RLAT);
    chk("rd_done_ready", {30'd0, rx_valid, tx_ready}, 32'd3);
    step(1);

    // back-to-back writes
    hs_log.delete();
    send(8'h11, 0, 8'h00);
    send(8'h22, 0, 8'h00);
    send(8'h33, 0, 8'h00);
    chk("b2b_gap1", hs_log[1] - hs_log[0], DW + 1);
    chk("b2b_gap2", hs_log[2] - hs_log[0], 2 * (DW + 1));
    step(DW + 2);

    // reset in the middle of a read
    send(8'h5A, 1, 8'h96);
    h = last_hs;
    wait_cycle(h + 14);
    step(1);
    nreset = 0;
    step(1);
    @(negedge clk);
    chk("rst_mid_rx",
        {20'd0, tx_ready, oe, ie, rx_valid, rx_data},
        32'd0);
    step(1);
    nreset = 1;
    @(negedge clk);
    chk("rst_release_ready", {31'd0, tx_ready}, 32'd1);
    step(1);
    send(8'hE7, 1, 8'h4D);
    step(RLAT + 2);

    // request during TX is ignored
    send(8'h00, 0, 8'h00);
    h0 = hs_cnt;
    step(2);
    tx_data  = 8'hFF;
    tx_valid = 1;
    step(1);
    tx_valid = 0;
    step(DW + 4);
    chk("ignored_req", hs_cnt - h0, 0);

    // randomized mixed traffic
    for (int i = 0; i < 1000; i++) begin
      step($urandom_range(0, 2));
      send(8'($urandom), 1'($urandom), 8'($urandom));
    end

    h = 0;
    while ((busy || exp_q.size() != 0) && h < 200) begin
      step(1);
      h++;
    end
    step(2);
    chk("drain", exp_q.size() + cmd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
